// File: rtl/param_shift_add_multiplier.sv
// Sequential shift-add multiplier, WIDTH-bit operands, 2*WIDTH-bit product in A:B.
// Define MULT_SIGNED_EN for two's-complement operands; otherwise operands are unsigned.
module param_shift_add_multiplier #(
    parameter int WIDTH      = 8,
    parameter int PIPE_SPLIT = 0
) (
    input  logic             i_clk,
    input  logic             i_reset_l,
    input  logic             i_execute,
    input  logic             i_clear_a_load_b,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_aval,
    output logic [WIDTH-1:0] o_bval,
    output logic             o_x,
    output logic             o_busy,
    output logic             o_done,
    output logic [1:0]       o_state
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] C_END  = CW'(WIDTH);
`ifdef MULT_SIGNED_EN
    localparam logic SIGNED_MODE = 1'b1;
`else
    localparam logic SIGNED_MODE = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ADD   = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t            r_state, w_state_nx;
    logic [WIDTH-1:0]  r_a, r_b, r_s;
    logic [WIDTH-1:0]  w_a_nx, w_b_nx, w_s_nx;
    logic              r_x, w_x_nx;
    logic [CW-1:0]     r_count, w_count_nx;
    logic              r_busy, w_busy_nx;
    logic              r_done, w_done_nx;

    logic [WIDTH:0]    w_ext_a, w_ext_s, w_sum, w_add_xa, w_sh_src_xa;
    logic              w_sub;
    logic [WIDTH-1:0]  w_shift_a, w_shift_b;
    logic              w_shift_x;

    // {X,A} is a WIDTH+1 bit accumulator; the last partial product is negative in signed mode.
    assign w_ext_a  = {SIGNED_MODE & r_a[WIDTH-1], r_a};
    assign w_ext_s  = {SIGNED_MODE & r_s[WIDTH-1], r_s};
    assign w_sub    = SIGNED_MODE && (r_count == C_LAST);
    assign w_sum    = w_sub ? (w_ext_a - w_ext_s) : (w_ext_a + w_ext_s);
    assign w_add_xa = r_b[0] ? w_sum : w_ext_a;

    // Merged mode shifts the freshly added value; split mode shifts the registered one.
    assign w_sh_src_xa = (PIPE_SPLIT != 0) ? {r_x, r_a} : w_add_xa;
    assign w_shift_a   = w_sh_src_xa[WIDTH:1];
    assign w_shift_b   = {w_sh_src_xa[0], r_b[WIDTH-1:1]};
    assign w_shift_x   = SIGNED_MODE & w_sh_src_xa[WIDTH];

    always_comb begin
        w_state_nx = r_state;
        w_a_nx     = r_a;
        w_b_nx     = r_b;
        w_s_nx     = r_s;
        w_x_nx     = r_x;
        w_count_nx = r_count;
        w_busy_nx  = r_busy;
        w_done_nx  = r_done;
        case (r_state)
            ST_IDLE: begin
                if (i_execute) begin
                    w_s_nx     = i_din;
                    w_count_nx = '0;
                    w_busy_nx  = 1'b1;
                    w_state_nx = ST_ADD;
                end else if (i_clear_a_load_b) begin
                    w_a_nx = '0;
                    w_x_nx = 1'b0;
                    w_b_nx = i_din;
                end
            end
            ST_ADD: begin
                if (r_count == C_END) begin
                    w_busy_nx  = 1'b0;
                    w_done_nx  = 1'b1;
                    w_state_nx = ST_DONE;
                end else if (PIPE_SPLIT != 0) begin
                    w_x_nx     = w_add_xa[WIDTH];
                    w_a_nx     = w_add_xa[WIDTH-1:0];
                    w_state_nx = ST_SHIFT;
                end else begin
                    w_x_nx     = w_shift_x;
                    w_a_nx     = w_shift_a;
                    w_b_nx     = w_shift_b;
                    w_count_nx = r_count + CW'(1);
                end
            end
            ST_SHIFT: begin
                w_x_nx     = w_shift_x;
                w_a_nx     = w_shift_a;
                w_b_nx     = w_shift_b;
                w_count_nx = r_count + CW'(1);
                w_state_nx = ST_ADD;
            end
            ST_DONE: begin
                // Holding Execute keeps us here so one press gives exactly one run.
                if (!i_execute) begin
                    w_done_nx  = 1'b0;
                    w_state_nx = ST_IDLE;
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_l) begin
            r_state <= ST_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_s     <= '0;
            r_x     <= 1'b0;
            r_count <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_a     <= w_a_nx;
            r_b     <= w_b_nx;
            r_s     <= w_s_nx;
            r_x     <= w_x_nx;
            r_count <= w_count_nx;
            r_busy  <= w_busy_nx;
            r_done  <= w_done_nx;
        end
    end

    assign o_aval  = r_a;
    assign o_bval  = r_b;
    assign o_x     = r_x;
    assign o_busy  = r_busy;
    assign o_done  = r_done;
    assign o_state = r_state;

endmodule

// File: tb/tb_param_shift_add_multiplier.sv
// Bench for param_shift_add_multiplier: merged and split instances driven in lockstep.
// Signed expectations apply when MULT_SIGNED_EN is defined.
module tb_param_shift_add_multiplier;

    localparam int W = 8;
`ifdef MULT_SIGNED_EN
    localparam bit SGN = 1'b1;
`else
    localparam bit SGN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_l = 1'b0;
    logic         exe = 1'b0;
    logic         clr = 1'b0;
    logic [W-1:0] din = '0;

    logic [W-1:0] a0, b0, a1, b1;
    logic         x0, x1, busy0, busy1, done0, done1;
    logic [1:0]   st0, st1;

    param_shift_add_multiplier #(.WIDTH(W), .PIPE_SPLIT(0)) dut0 (
        .i_clk(clk), .i_reset_l(rst_l), .i_execute(exe), .i_clear_a_load_b(clr), .i_din(din),
        .o_aval(a0), .o_bval(b0), .o_x(x0), .o_busy(busy0), .o_done(done0), .o_state(st0)
    );

    param_shift_add_multiplier #(.WIDTH(W), .PIPE_SPLIT(1)) dut1 (
        .i_clk(clk), .i_reset_l(rst_l), .i_execute(exe), .i_clear_a_load_b(clr), .i_din(din),
        .o_aval(a1), .o_bval(b1), .o_x(x1), .o_busy(busy1), .o_done(done1), .o_state(st1)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0]   b;
        logic [W-1:0]   s;
        logic [2*W-1:0] p;
        logic           x;
    } vec_t;
    vec_t vt[4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference: {A,B} after a run equals A_start + B*S in 2*W bits (A_start = 0 after a clear).
    function automatic logic [63:0] ref_full(input logic [W-1:0] a_in, input logic [W-1:0] b_in,
                                             input logic [W-1:0] s_in);
        longint av, bv, sv, p;
        logic [63:0] pu;
        if (SGN) begin
            av = longint'($signed(a_in));
            bv = longint'($signed(b_in));
            sv = longint'($signed(s_in));
        end else begin
            av = longint'(a_in);
            bv = longint'(b_in);
            sv = longint'(s_in);
        end
        p  = av + bv * sv;
        pu = p;
        return pu;
    endfunction

    function automatic logic [2*W-1:0] ref_p(input logic [W-1:0] a_in, input logic [W-1:0] b_in,
                                             input logic [W-1:0] s_in);
        logic [63:0] f;
        f = ref_full(a_in, b_in, s_in);
        return f[2*W-1:0];
    endfunction

    function automatic logic ref_x(input logic [W-1:0] a_in, input logic [W-1:0] b_in,
                                   input logic [W-1:0] s_in);
        logic [63:0] f;
        f = ref_full(a_in, b_in, s_in);
        return SGN ? f[2*W-1] : 1'b0;
    endfunction

    task automatic load_b(input logic [W-1:0] b, input string tag);
        clr = 1'b1;
        din = b;
        tick();
        clr = 1'b0;
        chk({tag, "_load0"}, 64'({a0, b0, x0}), 64'({{W{1'b0}}, b, 1'b0}));
        chk({tag, "_load1"}, 64'({a1, b1, x1}), 64'({{W{1'b0}}, b, 1'b0}));
    endtask

    // Starts a run and waits (bounded) for both instances to report Done; Execute stays high.
    task automatic run_mul(input logic [W-1:0] s, input logic [2*W-1:0] ep, input logic ex,
                           input bit clr_too, input bit disturb, input string tag);
        int lat0, lat1;
        exe = 1'b1;
        din = s;
        clr = clr_too;
        tick();
        clr = 1'b0;
        chk({tag, "_busy"}, 64'({busy0, busy1, done0, done1}), 64'(4'b1100));
        lat0 = 0;
        lat1 = 0;
        for (int n = 1; n <= 60 && (lat0 == 0 || lat1 == 0); n++) begin
            if (disturb) begin
                clr = 1'($urandom_range(0, 1));
                din = W'($urandom);
            end
            tick();
            if (done0 && lat0 == 0) lat0 = n;
            if (done1 && lat1 == 0) lat1 = n;
        end
        clr = 1'b0;
        chk({tag, "_lat0"}, 64'(lat0), 64'(W + 1));
        chk({tag, "_lat1"}, 64'(lat1), 64'(2 * W + 1));
        chk({tag, "_prod0"}, 64'({a0, b0}), 64'(ep));
        chk({tag, "_prod1"}, 64'({a1, b1}), 64'(ep));
        chk({tag, "_x"}, 64'({x0, x1}), 64'({ex, ex}));
    endtask

    task automatic release_exe(input string tag);
        exe = 1'b0;
        tick();
        chk({tag, "_release"}, 64'({done0, done1, busy0, busy1, st0, st1}), 64'(0));
    endtask

    initial begin
        logic [W-1:0]   rb, rs, pa, pb;
        logic [2*W-1:0] p;
        bit             held_ok;

        if (SGN) begin
            vt[0] = '{8'h07, 8'hC5, 16'hFE63, 1'b1};
            vt[1] = '{8'h80, 8'h80, 16'h4000, 1'b0};
            vt[2] = '{8'hFF, 8'hFF, 16'h0001, 1'b0};
            vt[3] = '{8'h00, 8'h5A, 16'h0000, 1'b0};
        end else begin
            vt[0] = '{8'h07, 8'hC5, 16'h0563, 1'b0};
            vt[1] = '{8'h80, 8'h80, 16'h4000, 1'b0};
            vt[2] = '{8'hFF, 8'hFF, 16'hFE01, 1'b0};
            vt[3] = '{8'h00, 8'h5A, 16'h0000, 1'b0};
        end

        // Clock/reset
        rst_l = 1'b0;
        tick();
        tick();
        rst_l = 1'b1;
        chk("reset_state", 64'({a0, b0, x0, busy0, done0, st0, a1, b1, x1, busy1, done1, st1}), 64'(0));

        // Directed vectors
        for (int i = 0; i < 4; i++) begin
            load_b(vt[i].b, $sformatf("vec%0d", i));
            run_mul(vt[i].s, vt[i].p, vt[i].x, 1'b0, 1'b0, $sformatf("vec%0d", i));
            release_exe($sformatf("vec%0d", i));
        end

        // Execute held long: one run only, Done stays up
        load_b(vt[0].b, "hold");
        run_mul(vt[0].s, vt[0].p, vt[0].x, 1'b0, 1'b0, "hold");
        held_ok = 1'b1;
        for (int n = 0; n < 50; n++) begin
            tick();
            if (!(done0 && done1 && !busy0 && !busy1)) held_ok = 1'b0;
            if ({a0, b0} !== vt[0].p || {a1, b1} !== vt[0].p) held_ok = 1'b0;
        end
        chk("hold_stable", 64'(held_ok), 64'(1));
        release_exe("hold");

        // Re-press without clearing: accumulates into the previous result
        pa = vt[0].p[2*W-1:W];
        pb = vt[0].p[W-1:0];
        run_mul(8'h03, ref_p(pa, pb, 8'h03), ref_x(pa, pb, 8'h03), 1'b0, 1'b0, "repress");
        release_exe("repress");

        // Reset in the middle of a run, then a normal run
        load_b(8'h07, "midrst");
        exe = 1'b1;
        din = 8'hC5;
        tick();
        tick();
        tick();
        rst_l = 1'b0;
        exe = 1'b0;
        tick();
        chk("midrst_zero", 64'({a0, b0, x0, busy0, done0, st0, a1, b1, x1, busy1, done1, st1}), 64'(0));
        rst_l = 1'b1;
        load_b(vt[0].b, "after_rst");
        run_mul(vt[0].s, vt[0].p, vt[0].x, 1'b0, 1'b0, "after_rst");
        release_exe("after_rst");

        // Din and ClearA_LoadB wiggled while busy are ignored
        load_b(vt[0].b, "disturb");
        run_mul(vt[0].s, vt[0].p, vt[0].x, 1'b0, 1'b1, "disturb");
        release_exe("disturb");

        // Execute and ClearA_LoadB together in IDLE: multiply wins, B kept
        load_b(vt[0].b, "both");
        run_mul(vt[0].s, vt[0].p, vt[0].x, 1'b1, 1'b0, "both");
        release_exe("both");

        // Random operands against the reference model
        for (int i = 0; i < 16; i++) begin
            rb = W'($urandom);
            rs = W'($urandom);
            p  = ref_p('0, rb, rs);
            load_b(rb, $sformatf("rand%0d", i));
            run_mul(rs, p, ref_x('0, rb, rs), 1'b0, 1'b0, $sformatf("rand%0d", i));
            release_exe($sformatf("rand%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
